// File: rtl/grn_attractor_ctrl.sv
// Attractor search controller for a gene-regulatory network with slow (s0) and fast (s1) state copies.
// Optional macro GRN_ABORT_EN adds an abort input that ends a run early with no result.
module grn_attractor_ctrl #(
  parameter int NODES = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NODES-1:0] init_vec,
  input  logic [CNT_W-1:0] max_steps,
  input  logic [NODES-1:0] nodes_s0,
  input  logic [NODES-1:0] nodes_s1,
`ifdef GRN_ABORT_EN
  input  logic             abort,
`endif
  output logic             reset_nos,
  output logic [NODES-1:0] init_state,
  output logic             start_s0,
  output logic             start_s1,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             timeout,
  output logic [CNT_W-1:0] meet_steps,
  output logic [CNT_W-1:0] period
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_PERIOD = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]       state;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] step_cnt;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] step_next;
  logic [CNT_W-1:0] per_vis;
  logic [NODES-1:0] ref_state;
  logic             abort_hit;
  logic             meet;
  logic             match;

`ifdef GRN_ABORT_EN
  assign abort_hit = abort && busy;
`else
  assign abort_hit = 1'b0;
`endif

  assign busy = (state == S_LOAD) || (state == S_RUN) || (state == S_PERIOD);
  assign done = (state == S_DONE);

  assign reset_nos = (state == S_LOAD) && !abort_hit;
  assign start_s0  = (state == S_RUN) && !abort_hit;
  assign start_s1  = ((state == S_RUN) || (state == S_PERIOD)) && !abort_hit;

  assign step_next = (step_cnt == CNT_MAX) ? step_cnt : step_cnt + 1'b1;

  // per_cnt holds the s1 steps already seen; the strobe issued in the meet cycle
  // becomes visible in the first PERIOD cycle, so the current view is one further on.
  assign per_vis = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + 1'b1;

  assign meet  = (state == S_RUN) && !step_cnt[0] && (step_cnt != '0) && (nodes_s0 == nodes_s1);
  assign match = (state == S_PERIOD) && (per_vis != '0) && (nodes_s1 == ref_state);

  // NOTE: all state updates use non-blocking assignments so every register samples
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      init_state <= '0;
      limit      <= '0;
      step_cnt   <= '0;
      per_cnt    <= '0;
      ref_state  <= '0;
      found      <= 1'b0;
      timeout    <= 1'b0;
      meet_steps <= '0;
      period     <= '0;
    end else if (abort_hit) begin
      state   <= S_DONE;
      found   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            init_state <= init_vec;
            limit      <= (max_steps == '0) ? CNT_MAX : max_steps;
            found      <= 1'b0;
            timeout    <= 1'b0;
            meet_steps <= '0;
            period     <= '0;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          step_cnt <= '0;
          state    <= S_RUN;
        end
        S_RUN: begin
          if (meet) begin
            meet_steps <= step_cnt;
            ref_state  <= nodes_s0;
            per_cnt    <= '0;
            state      <= S_PERIOD;
          end else if (step_cnt == limit) begin
            timeout <= 1'b1;
            found   <= 1'b0;
            state   <= S_DONE;
          end else begin
            step_cnt <= step_next;
          end
        end
        S_PERIOD: begin
          if (match) begin
            period <= per_vis;
            found  <= 1'b1;
            state  <= S_DONE;
          end else if (per_vis == limit) begin
            timeout <= 1'b1;
            found   <= 1'b0;
            state   <= S_DONE;
          end else begin
            per_cnt <= per_vis;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// Bench for grn_attractor_ctrl: emulates a 3-node network and checks results against
// a reference that iterates the update rule directly.
module tb_grn_attractor_ctrl;

  localparam int NODES = 3;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [NODES-1:0] init_vec;
  logic [CNT_W-1:0] max_steps;
  logic [NODES-1:0] nodes_s0;
  logic [NODES-1:0] nodes_s1;
`ifdef GRN_ABORT_EN
  logic             abort;
`endif
  logic             reset_nos;
  logic [NODES-1:0] init_state;
  logic             start_s0;
  logic             start_s1;
  logic             busy;
  logic             done;
  logic             found;
  logic             timeout;
  logic [CNT_W-1:0] meet_steps;
  logic [CNT_W-1:0] period;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Update rule: 0 rotate-left, 1 identity, 2 random table, 3 increment mod 8.
  int         rule;
  logic [2:0] lut [8];
  logic       s0_par;

  always #5 clk = ~clk;

  grn_attractor_ctrl #(.NODES(NODES), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .init_vec   (init_vec),
    .max_steps  (max_steps),
    .nodes_s0   (nodes_s0),
    .nodes_s1   (nodes_s1),
`ifdef GRN_ABORT_EN
    .abort      (abort),
`endif
    .reset_nos  (reset_nos),
    .init_state (init_state),
    .start_s0   (start_s0),
    .start_s1   (start_s1),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .timeout    (timeout),
    .meet_steps (meet_steps),
    .period     (period)
  );

  function automatic logic [2:0] step_f(input logic [2:0] s);
    case (rule)
      0:       return {s[1:0], s[2]};
      1:       return s;
      2:       return lut[s];
      default: return s + 3'd1;
    endcase
  endfunction

  function automatic logic [2:0] pw(input logic [2:0] s, input int n);
    logic [2:0] v = s;
    for (int i = 0; i < n; i++) v = step_f(v);
    return v;
  endfunction

  // Network emulation: s1 steps on every strobe, s0 on every second one.
  always @(posedge clk) begin
    if (reset_nos) begin
      nodes_s0 <= init_state;
      nodes_s1 <= init_state;
      s0_par   <= 1'b0;
    end else begin
      if (start_s1) nodes_s1 <= step_f(nodes_s1);
      if (start_s0) begin
        s0_par <= ~s0_par;
        if (s0_par) nodes_s0 <= step_f(nodes_s0);
      end
    end
  end

  // Reference: Floyd-style search over the rule, with the step limit applied in each phase.
  task automatic model(input logic [2:0] init, input logic [CNT_W-1:0] maxs,
                       output bit e_found, output bit e_to, output int e_meet,
                       output int e_per, output int e_cyc, output int e_s0, output int e_s1);
    int lim = (maxs == 0) ? (1 << CNT_W) - 1 : int'(maxs);
    int m = -1;
    logic [2:0] r;
    e_found = 0; e_to = 0; e_meet = 0; e_per = 0;
    for (int k = 0; k <= lim; k++) begin
      if (k > 0 && k % 2 == 0 && pw(init, k / 2) == pw(init, k)) begin
        m = k;
        break;
      end
      if (k == lim) begin
        e_to = 1; e_cyc = 3 + k; e_s0 = k + 1; e_s1 = k + 1;
      end
    end
    if (m >= 0) begin
      e_meet = m;
      r = pw(init, m);
      e_s0 = m + 1;
      for (int p = 1; p <= lim; p++) begin
        if (pw(r, p) == r) begin
          e_found = 1; e_per = p; e_cyc = 3 + m + p; e_s1 = m + 1 + p;
          break;
        end
        if (p == lim) begin
          e_to = 1; e_cyc = 3 + m + p; e_s1 = m + 1 + p;
        end
      end
    end
  endtask

  task automatic run_case(input string name, input logic [2:0] init,
                          input logic [CNT_W-1:0] maxs, input bit poke_start);
    bit e_found, e_to;
    int e_meet, e_per, e_cyc, e_s0, e_s1;
    int c = 0, n_ld = 0, n_s0 = 0, n_s1 = 0, busy_gap = 0;
    bit got = 0;
    model(init, maxs, e_found, e_to, e_meet, e_per, e_cyc, e_s0, e_s1);
    @(negedge clk);
    start = 1'b1; init_vec = init; max_steps = maxs;
    while (!got && c < 1000) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      if (poke_start && c == 4) begin
        start = 1'b1; init_vec = ~init; max_steps = 8'd1;
      end
      if (reset_nos) n_ld++;
      if (start_s0)  n_s0++;
      if (start_s1)  n_s1++;
      if (done) got = 1;
      else if (!busy) busy_gap++;
    end
    start = 1'b0;
    check_cnt++;
    if (!got || c !== e_cyc) $display("FAIL %s done_cycle: got %0d (seen=%0d) expected %0d", name, c, got, e_cyc);
    else pass_cnt++;
    check_cnt++;
    if (found !== e_found || timeout !== e_to)
      $display("FAIL %s flags: found=%b timeout=%b expected %b %b", name, found, timeout, e_found, e_to);
    else pass_cnt++;
    check_cnt++;
    if (meet_steps !== CNT_W'(e_meet) || period !== CNT_W'(e_per))
      $display("FAIL %s result: meet=%0d period=%0d expected %0d %0d", name, meet_steps, period, e_meet, e_per);
    else pass_cnt++;
    check_cnt++;
    if (n_ld !== 1 || n_s0 !== e_s0 || n_s1 !== e_s1)
      $display("FAIL %s strobes: load=%0d s0=%0d s1=%0d expected 1 %0d %0d", name, n_ld, n_s0, n_s1, e_s0, e_s1);
    else pass_cnt++;
    check_cnt++;
    if (busy_gap !== 0 || busy !== 1'b0 || init_state !== init)
      $display("FAIL %s busy/init: gaps=%0d busy_at_done=%b init=%b expected 0 0 %b", name, busy_gap, busy, init_state, init);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || found !== e_found || timeout !== e_to)
      $display("FAIL %s after_done: done=%b busy=%b found=%b timeout=%b expected 0 0 %b %b",
               name, done, busy, found, timeout, e_found, e_to);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; init_vec = '0; max_steps = '0;
`ifdef GRN_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_cnt++;
    if ({reset_nos, start_s0, start_s1, busy, done, found, timeout} !== 7'b0)
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {reset_nos, start_s0, start_s1, busy, done, found, timeout});
    else pass_cnt++;
    check_cnt++;
    if (meet_steps !== '0 || period !== '0 || init_state !== '0)
      $display("FAIL reset_data: meet=%0d period=%0d init=%b expected 0 0 000", meet_steps, period, init_state);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    rule = 0; run_case("rotate", 3'b001, 8'd100, 1'b0);
    rule = 1; run_case("identity", 3'b101, 8'd100, 1'b0);
    rule = 0; run_case("rotate_timeout", 3'b001, 8'd4, 1'b0);
    rule = 3; run_case("inc_meet_on_limit", 3'b000, 8'd16, 1'b0);
    rule = 3; run_case("inc_limit_zero", 3'b010, 8'd0, 1'b0);
  endtask

  task automatic test_reset_mid_period();
    int c = 0;
    rule = 0;
    @(negedge clk);
    start = 1'b1; init_vec = 3'b001; max_steps = 8'd100;
    @(negedge clk);
    start = 1'b0;
    while (!(start_s1 && !start_s0) && c < 50) begin
      @(negedge clk);
      c++;
    end
    check_cnt++;
    if (c >= 50) $display("FAIL mid_reset_reach_period: waited %0d cycles expected < 50", c);
    else pass_cnt++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_cnt++;
    if ({reset_nos, start_s0, start_s1, busy, done, found, timeout} !== 7'b0 ||
        meet_steps !== '0 || period !== '0 || init_state !== '0)
      $display("FAIL mid_reset_state: ctrl=%b meet=%0d period=%0d init=%b expected all zero",
               {reset_nos, start_s0, start_s1, busy, done, found, timeout}, meet_steps, period, init_state);
    else pass_cnt++;
    run_case("rotate_after_reset", 3'b001, 8'd100, 1'b0);
  endtask

  task automatic test_back_to_back();
    rule = 0;
    run_case("start_in_run", 3'b001, 8'd100, 1'b1);
    rule = 1;
    run_case("identity_b2b", 3'b011, 8'd3, 1'b0);
  endtask

  task automatic test_random();
    rule = 2;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 8; i++) lut[i] = 3'($urandom_range(0, 7));
      run_case($sformatf("random_%0d", n), 3'($urandom_range(0, 7)),
               CNT_W'($urandom_range(0, 12)), 1'b0);
    end
  endtask

`ifdef GRN_ABORT_EN
  task automatic test_abort();
    rule = 0;
    @(negedge clk);
    start = 1'b1; init_vec = 3'b001; max_steps = 8'd100;
    repeat (4) @(negedge clk);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_cnt++;
    if (done !== 1'b1 || found !== 1'b0 || timeout !== 1'b0 || {reset_nos, start_s0, start_s1} !== 3'b0)
      $display("FAIL abort: done=%b found=%b timeout=%b strobes=%b expected 1 0 0 000",
               done, found, timeout, {reset_nos, start_s0, start_s1});
    else pass_cnt++;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_period();
    test_back_to_back();
    test_random();
`ifdef GRN_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
